// File: rtl/tdm_pkg.sv
// Shared definitions for the 4-channel TDM link (transmit and receive sides).
// Optional feature: define TDM_PARITY_EN to append one even-parity bit per slot.
package tdm_pkg;

    localparam int CH_NUM = 4;

`ifdef TDM_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif

    typedef enum logic {
        HUNT = 1'b0,
        RECV = 1'b1
    } state_t;

    typedef logic [1:0] slot_t;

    // Even parity: the parity bit equals the XOR of the data bits.
    function automatic logic even_par(input logic [15:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/tdm_slot_shift.sv
// Slot deserialiser: MSB-first shift register, bit counter and optional parity check.
// Parity bit handling is present only when TDM_PARITY_EN is defined.
module tdm_slot_shift
    import tdm_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         din,
    input  logic         load,
    input  logic         shift,
    output logic [W-1:0] word,
    output logic         done,
    output logic         par_ok,
    output logic         first
);

    localparam int SLOT_BITS = W + PAR_BITS;
    localparam int SR_W      = SLOT_BITS - 1;
    localparam int CNT_W     = $clog2(SLOT_BITS);

    logic [SR_W-1:0]      sr;
    logic [CNT_W-1:0]     bit_cnt;
    logic [SLOT_BITS-1:0] nxt;

    // The completed slot is taken from the shift path so the word is ready on its last bit.
    assign nxt   = {sr, din};
    assign done  = shift && (bit_cnt == CNT_W'(SLOT_BITS - 1));
    assign first = (bit_cnt == '0);

`ifdef TDM_PARITY_EN
    assign word   = nxt[SLOT_BITS-1:1];
    assign par_ok = (even_par(16'(word)) == nxt[0]);
`else
    assign word   = nxt;
    assign par_ok = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr      <= '0;
            bit_cnt <= '0;
        end else if (load) begin
            sr      <= SR_W'(din);
            bit_cnt <= CNT_W'(1);
        end else if (shift) begin
            sr      <= nxt[SR_W-1:0];
            bit_cnt <= done ? '0 : bit_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/tdm_demux4_rx.sv
// Receive side of the 4-channel TDM link: frame sync FSM, slot counter, per-channel registers.
// Build option TDM_PARITY_EN enables per-slot even parity and the par_err pulse.
module tdm_demux4_rx
    import tdm_pkg::*;
#(
    parameter int W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                din,
    input  logic                din_vld,
    input  logic                sof,
    output logic [CH_NUM*W-1:0] ch_data,
    output logic [1:0]          ch_sel,
    output logic                word_vld,
    output logic [1:0]          word_ch,
    output logic                frame_vld,
    output logic                sync_err,
    output logic                par_err
);

    state_t       state;
    slot_t        slot;
    logic [W-1:0] word;
    logic         done;
    logic         par_ok;
    logic         first;
    logic         frame_start;
    logic         load;
    logic         shift;
    logic         sof_err;
    logic         miss_err;

    // Any sof restarts a frame; only a sof exactly on the first bit of slot 0 is legal in RECV.
    always_comb begin
        frame_start = (slot == 2'd0) && first;
        load        = din_vld && sof;
        shift       = din_vld && !sof && (state == RECV) && !frame_start;
        sof_err     = din_vld && sof && (state == RECV) && !frame_start;
        miss_err    = din_vld && !sof && (state == RECV) && frame_start;
    end

    tdm_slot_shift #(.W(W)) u_shift (
        .clk    (clk),
        .rst_n  (rst_n),
        .din    (din),
        .load   (load),
        .shift  (shift),
        .word   (word),
        .done   (done),
        .par_ok (par_ok),
        .first  (first)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= HUNT;
            slot      <= 2'd0;
            ch_data   <= '0;
            word_vld  <= 1'b0;
            word_ch   <= 2'd0;
            frame_vld <= 1'b0;
            sync_err  <= 1'b0;
        end else begin
            word_vld  <= 1'b0;
            frame_vld <= 1'b0;
            sync_err  <= sof_err || miss_err;
            if (load) begin
                state <= RECV;
                slot  <= 2'd0;
            end else if (miss_err) begin
                state <= HUNT;
                slot  <= 2'd0;
            end else if (done) begin
                slot      <= slot + 2'd1;
                frame_vld <= (slot == 2'd3);
                if (par_ok) begin
                    ch_data[int'(slot)*W +: W] <= word;
                    word_vld <= 1'b1;
                    word_ch  <= slot;
                end
            end
        end
    end

`ifdef TDM_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) par_err <= 1'b0;
        else        par_err <= done && !par_ok;
    end
`else
    assign par_err = 1'b0;
`endif

    assign ch_sel = slot;

endmodule

// File: tb/tb_tdm_demux4_rx.sv
// Directed bench for tdm_demux4_rx with a word scoreboard; honours TDM_PARITY_EN when defined.
module tb_tdm_demux4_rx;

    localparam int W = 8;
`ifdef TDM_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int SB = W + PB;

    logic           clk;
    logic           rst_n;
    logic           din;
    logic           din_vld;
    logic           sof;
    logic [4*W-1:0] ch_data;
    logic [1:0]     ch_sel;
    logic           word_vld;
    logic [1:0]     word_ch;
    logic           frame_vld;
    logic           sync_err;
    logic           par_err;

    int total = 0;
    int bad = 0;
    int sync_cnt = 0;
    int par_cnt = 0;
    int frame_cnt = 0;
    int wv_cnt = 0;
    int cyc = 0;
    int prev_wv_cyc = 0;
    int last_wv_cyc = 0;
    logic [W+1:0] exp_q[$];

    tdm_demux4_rx #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din),
        .din_vld   (din_vld),
        .sof       (sof),
        .ch_data   (ch_data),
        .ch_sel    (ch_sel),
        .word_vld  (word_vld),
        .word_ch   (word_ch),
        .frame_vld (frame_vld),
        .sync_err  (sync_err),
        .par_err   (par_err)
    );

    // clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // scoreboard: every word_vld must match the oldest expected {channel, word}
    always @(negedge clk) begin
        if (rst_n) begin
            if (sync_err) sync_cnt++;
            if (par_err) par_cnt++;
            if (frame_vld) frame_cnt++;
            if (word_vld) begin
                logic [W+1:0] e;
                wv_cnt++;
                prev_wv_cyc = last_wv_cyc;
                last_wv_cyc = cyc;
                check("word_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("word_ch", 32'(word_ch), 32'(e[W+1:W]));
                    check("word_data", 32'(ch_data[word_ch*W +: W]), 32'(e[W-1:0]));
                    check("frame_vld", 32'(frame_vld), 32'(e[W+1:W] == 2'd3));
                end
            end
        end
    end

    // driver tasks
    task automatic send_bit(input logic b, input logic s);
        din     = b;
        sof     = s;
        din_vld = 1'b1;
        @(posedge clk);
        #1;
        din_vld = 1'b0;
        sof     = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic send_word(input logic [1:0] ch, input logic [W-1:0] w, input bit with_sof,
                             input bit expect_wr, input bit gap, input bit flip, input int top_bit);
        for (int i = top_bit; i >= 0; i--) begin
            if (i == 0 && PB == 0 && expect_wr) exp_q.push_back({ch, w});
            send_bit(w[i], with_sof && (i == top_bit));
            if (gap) idle(1);
        end
        if (PB == 1) begin
            if (expect_wr) exp_q.push_back({ch, w});
            send_bit((^w) ^ flip, 1'b0);
            if (gap) idle(1);
        end
    endtask

    task automatic send_frame(input logic [4*W-1:0] f, input bit gap);
        for (int k = 0; k < 4; k++)
            send_word(2'(k), f[k*W +: W], k == 0, 1'b1, gap, 1'b0, W - 1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle(2);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
    endtask

    initial begin
        int s0;
        int f0;
        int w0;
        logic [31:0] exp_last;
        din = 1'b0;
        din_vld = 1'b0;
        sof = 1'b0;
        rst_n = 1'b0;

        // reset with random activity on the inputs
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            din = 1'($urandom_range(0, 1));
            din_vld = 1'($urandom_range(0, 1));
            sof = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("rst_ch_data", ch_data, 32'h0);
            check("rst_flags", {24'h0, ch_sel, word_vld, word_ch, frame_vld, sync_err, par_err}, 32'h0);
        end
        din_vld = 1'b0;
        sof = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);

        // sof without din_vld is ignored in HUNT
        sof = 1'b1;
        din = 1'b1;
        idle(3);
        sof = 1'b0;
        settle();
        check("novld_sof_words", 32'(wv_cnt), 32'd0);
        check("novld_sof_sync", 32'(sync_cnt), 32'd0);

        // clean frame then a back-to-back second frame
        send_word(2'd0, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, W - 1);
        check("ch_sel_after_slot0", 32'(ch_sel), 32'd1);
        send_word(2'd1, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, W - 1);
        send_word(2'd2, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, W - 1);
        send_word(2'd3, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0, W - 1);
        check("clean_ch_data", ch_data, 32'h01FF3CA5);
        send_frame(32'h40302010, 1'b0);
        settle();
        check("b2b_ch_data", ch_data, 32'h40302010);
        check("clean_frames", 32'(frame_cnt), 32'd2);
        check("clean_words", 32'(wv_cnt), 32'd8);
        check("clean_spacing", 32'(last_wv_cyc - prev_wv_cyc), 32'(SB));
        check("clean_sync", 32'(sync_cnt), 32'd0);
        check("clean_ch_sel", 32'(ch_sel), 32'd0);

        // gapped input after a reset
        do_reset();
        check("reset_clears", ch_data, 32'h0);
        w0 = wv_cnt;
        send_frame(32'h01FF3CA5, 1'b1);
        settle();
        check("gap_ch_data", ch_data, 32'h01FF3CA5);
        check("gap_words", 32'(wv_cnt - w0), 32'd4);
        check("gap_spacing", 32'(last_wv_cyc - prev_wv_cyc), 32'(2 * SB));

        // sof on bit 4 of slot 1
        s0 = sync_cnt;
        send_word(2'd0, 8'h77, 1'b1, 1'b1, 1'b0, 1'b0, W - 1);
        for (int i = 0; i < 4; i++) send_bit(1'(i), 1'b0);
        send_bit(1'b0, 1'b1);
        check("sof_err_timing", 32'(sync_err), 32'd1);
        send_word(2'd0, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, W - 2);
        settle();
        check("midsof_sync", 32'(sync_cnt - s0), 32'd1);
        check("midsof_ch1_kept", 32'(ch_data[15:8]), 32'h3C);
        check("midsof_ch0_new", 32'(ch_data[7:0]), 32'h5A);
        send_word(2'd1, 8'h12, 1'b0, 1'b1, 1'b0, 1'b0, W - 1);
        send_word(2'd2, 8'h34, 1'b0, 1'b1, 1'b0, 1'b0, W - 1);
        send_word(2'd3, 8'h56, 1'b0, 1'b1, 1'b0, 1'b0, W - 1);
        settle();
        check("midsof_ch_data", ch_data, 32'h5634125A);

        // next frame missing its sof
        s0 = sync_cnt;
        w0 = wv_cnt;
        send_word(2'd0, 8'h8B, 1'b0, 1'b0, 1'b0, 1'b0, W - 1);
        settle();
        check("miss_sync", 32'(sync_cnt - s0), 32'd1);
        check("miss_no_write", 32'(wv_cnt - w0), 32'd0);
        check("miss_ch_sel", 32'(ch_sel), 32'd0);
        check("miss_ch_data", ch_data, 32'h5634125A);

        // reset in the middle of slot 1, then a clean frame
        send_word(2'd0, 8'hAA, 1'b1, 1'b1, 1'b0, 1'b0, W - 1);
        for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_ch_data", ch_data, 32'h0);
        check("midrst_ch_sel", 32'(ch_sel), 32'd0);
        rst_n = 1'b1;
        idle(1);
        f0 = frame_cnt;
        s0 = par_cnt;
        send_word(2'd0, 8'h11, 1'b1, 1'b1, 1'b0, 1'b0, W - 1);
        send_word(2'd1, 8'h22, 1'b0, 1'b1, 1'b0, 1'b0, W - 1);
        send_word(2'd2, 8'h33, 1'b0, PB == 0, 1'b0, 1'b1, W - 1);
        send_word(2'd3, 8'h44, 1'b0, 1'b1, 1'b0, 1'b0, W - 1);
        settle();
        exp_last = (PB == 1) ? 32'h44002211 : 32'h44332211;
        check("final_ch_data", ch_data, exp_last);
        check("final_frame", 32'(frame_cnt - f0), 32'd1);
        check("final_par_err", 32'(par_cnt - s0), 32'(PB));
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tdm_demux4_rx.md
# tdm_demux4_rx

Receive end of the 4-channel time-division link whose transmit side is the 4:1 multiplexer datapath. Takes a single serial bit stream carrying four fixed-width slots per frame, finds the frame boundary, deserialises each slot MSB first, and latches each word into its own per-channel output register. It sits between the serial link pin/synchroniser and the per-channel consumers.

## Interface
- W, 8: slot payload width in bits (2..16).
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- din  in  1  serial data bit, sampled only when din_vld=1.
- din_vld  in  1  din qualifier; one bit per asserted cycle.
- sof  in  1  start of frame; meaningful only with din_vld=1; marks bit 0 (MSB) of slot 0.
- ch_data  out  4*W  channel words; channel k is bits [k*W +: W].
- ch_sel  out  2  slot currently being received.
- word_vld  out  1  one-cycle pulse: a word was just written.
- word_ch  out  2  channel written, valid with word_vld.
- frame_vld  out  1  one-cycle pulse: slot 3 was written.
- sync_err  out  1  one-cycle pulse on framing violation.
- par_err  out  1  one-cycle pulse on parity mismatch; constant 0 when parity is compiled out.

## Operation
- States: HUNT, RECV.
- HUNT: bits without sof are discarded. On din_vld&sof: shift in din, bit_cnt=1, slot=0, go RECV.
- RECV: each din_vld shifts din into the shift register MSB first, bit_cnt+1.
- Slot complete (bit_cnt reaches SLOT_BITS-1 on a din_vld): word written to ch_data[slot], word_vld/word_ch pulse, bit_cnt=0, slot+1 (wraps 3->0).
- Slot 3 complete: frame_vld pulses together with word_vld.
- First bit of slot 0 must carry sof. A missing sof gives a sync_err pulse, the bit is discarded, and the block goes to HUNT.
- sof on any other bit (mid-slot or slot 1..3): sync_err pulse, partial word discarded, bit taken as MSB of slot 0 of a new frame, stays in RECV.
- Words already written stay in ch_data until overwritten; errors never clear them.
- ch_sel = current slot counter (0 in HUNT).
- SLOT_BITS = W, or W+1 with parity.

## Timing
- Reset (async assert, sync deassert by the caller): state=HUNT, ch_data=0, ch_sel=0, word_vld=0, word_ch=0, frame_vld=0, sync_err=0, par_err=0, counters and shift register 0.
- Reset mid-frame: all progress is lost and the block re-hunts.
- Latency: ch_data, word_vld, word_ch and frame_vld update on the clock edge that samples the last bit of the slot. They are visible in the following cycle.
- sync_err and par_err are registered and appear one cycle after the offending sample.
- din_vld gaps of any length are allowed; state holds.
- Throughput: one bit per cycle sustained. Back-to-back frames need no idle bits.

## Configuration
- TDM_PARITY_EN defined: each slot carries W data bits plus one trailing even-parity bit.
  - Mismatch: par_err pulses, word_vld is suppressed, and ch_data[slot] is not written.
  - The slot counter still advances, and frame_vld still pulses at the end of slot 3.
- TDM_PARITY_EN undefined: slots are W bits and par_err is tied 0.

## Structure
- Shared package tdm_pkg holds:
  - CH_NUM=4;
  - the state enum (HUNT, RECV);
  - the slot index typedef (2-bit);
  - the parity helper function.
  The transmitter reuses this package.
- Sub-module tdm_slot_shift contains the shift register, bit counter and parity check. It outputs word, done and par_ok. The top holds the FSM, slot counter and output registers.

## Test plan
All scenarios use W=8.
- Reset: hold rst_n=0, drive random din/din_vld -> all outputs 0, ch_sel=0.
- Clean frame: sof with first bit, slots 0xA5, 0x3C, 0xFF, 0x01 sent back-to-back:
  - ch_data = 0x01FF3CA5;
  - four word_vld pulses with word_ch 0,1,2,3;
  - frame_vld pulses with the slot-3 word_vld.
- Gapped input: same frame with din_vld low every other cycle -> identical ch_data; pulses are spaced by the gaps.
- Mid-slot sof: sof on bit 4 of slot 1:
  - sync_err pulses once;
  - ch_data[1] is unchanged;
  - the next 8 bits (0x5A) land in ch_data[0].
- Missing sof: the second frame's first bit has no sof -> sync_err pulses and the block goes to HUNT. Nothing is written until the next sof.
- Reset mid-slot, then a clean frame of 0x11, 0x22, 0x33, 0x44 -> ch_data = 0x44332211. With TDM_PARITY_EN, a flipped parity bit on slot 2 gives par_err, no word_vld, and ch_data[2] stays 0.
